rect_plot_arbiter: RTL
======================

# rect_plot_arbiter

Shares the single VGA-adapter pixel write port among `NUM_REQ` rectangle drawers: stairs, player, background erasers. Each requester asks for one filled rectangle (position, size, colour). The block grants requesters round-robin, latches the request, and rasterises it one pixel per clock onto `out_x`/`out_y`/`out_colour`/`plot`. When the last pixel is emitted it pulses `done` to the owner. It sits between the per-object FSMs and the `vga_adapter` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.

Ports:
- `clock` in 1: system clock (50 MHz).
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `req` in `NUM_REQ`: request level per requester; held until its `done`.
- `req_x` in `NUM_REQ*8`: packed rectangle left x; slot i is `[8i+7:8i]`.
- `req_y` in `NUM_REQ*7`: packed rectangle top y.
- `req_w` in `NUM_REQ*6`: packed width in pixels, 0..63.
- `req_h` in `NUM_REQ*4`: packed height in pixels, 0..15.
- `req_colour` in `NUM_REQ*3`: packed fill colour.
- `grant` out `NUM_REQ`: one-hot; high from GRANT through DONE for the owner.
- `done` out `NUM_REQ`: one-cycle pulse to the owner after its last pixel.
- `out_x` out 8, `out_y` out 7, `out_colour` out 3: pixel to write.
- `plot` out 1: write enable for the VGA adapter.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT, DRAW, DONE.
- IDLE
  - If any `req` bit is high, pick the winner by round-robin: the first set bit searching upward from pointer `rr`, wrapping modulo `NUM_REQ`.
  - Then go to GRANT.
- GRANT (1 cycle)
  - `grant[win]`=1.
  - Latch x, y, w, h, colour of the winner into internal registers. Requester inputs are don't-care after this cycle.
  - Clear offsets `qx`=0, `qy`=0.
  - If w==0 or h==0, go to DONE (zero pixels emitted). Otherwise go to DRAW.
- DRAW
  - Emit one pixel per cycle in row-major order: `out_x`=x+qx, `out_y`=y+qy.
  - `qx` increments; at `qx`==w-1 it wraps to 0 and `qy` increments.
  - The pixel with `qx`==w-1 and `qy`==h-1 is the last; the next state is DONE.
- DONE (1 cycle)
  - `done[win]`=1; `grant[win]` still 1.
  - `rr` ← (win+1) mod `NUM_REQ`.
  - Next state is IDLE.
- Clipping
  - Sums are computed 9-bit (x) and 8-bit (y).
  - A pixel with x+qx ≥ 160, y+qy ≥ 120, or a sum carry is still visited (it consumes its cycle) but has `plot`=0.
  - `out_x`/`out_y` carry the truncated sums.
- `plot`=1 only in DRAW for in-screen pixels. `out_colour`=latched colour in DRAW, else 0.
- Dropping `req` after GRANT does not abort: the rectangle completes and `done` still pulses.
- A requester must deassert `req` on the edge after its `done`. If it is still high in the following IDLE, it competes again at lowest priority.
- Reset asserted in any state, including mid-DRAW: immediate return to IDLE, `rr`=0, counters 0, no `done` pulse.

## Timing
- Reset values: `grant`=0, `done`=0, `out_x`=0, `out_y`=0, `out_colour`=0, `plot`=0, `busy`=0.
- `req` sampled in IDLE at cycle t:
  - GRANT at t+1.
  - First pixel at t+2.
  - Last pixel at t+1+w·h.
  - `done` at t+2+w·h.
  - IDLE at t+3+w·h.
- Occupancy: w·h+3 cycles per rectangle; zero-area rectangles take 3 cycles (IDLE, GRANT, DONE).
- All outputs are registered or decoded from registered state only; no combinational path from `req*` to outputs.
- Maximum rectangle: 63×15 = 945 pixels, 948 cycles.

## Structure
- Shared package `plot_pkg`:
  - `SCREEN_W`=160, `SCREEN_H`=120.
  - Coordinate widths 8/7, size widths 6/4, colour width 3.
  - State encoding for IDLE/GRANT/DRAW/DONE.
- Sub-module `rr_pick`: combinational round-robin selector taking `req` and `rr`, producing one-hot winner plus index and a `valid` flag. It is reusable by other shared-resource arbiters.
- Top-level holds the FSM, latched request registers, `qx`/`qy` raster counters and clip logic.

## Test plan
- Single request: req[1] with x=10, y=20, w=3, h=2, colour=3'b100.
  - Expect grant[1] one cycle later.
  - Expect 6 `plot` pulses at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 100.
  - Expect done[1] one cycle after the last pixel; 9 cycles total.
- Contention: req=4'b1111 held, all w=1 and h=1, with each requester dropping `req` after its `done`.
  - Expect grant order 0,1,2,3.
  - Then re-raise req[0] and req[2] only: expect grant order 0,2.
- Clipping: x=158, y=119, w=4, h=2.
  - Expect 8 DRAW cycles with `plot`=1 only at (158,119) and (159,119).
  - Expect `done` still pulsed.
- Zero area: w=0, h=5.
  - Expect grant then `done` within 3 cycles, and no `plot`.
- Reset mid-draw: a 40×10 request, assert `reset` at pixel 100.
  - Expect all outputs 0 immediately and no `done` pulse.
  - After reset release with req[2] high, expect grant[2] from `rr`=0 search.
- Request change after grant: alter req_x[0] during DRAW.
  - Expect the emitted pixels to use the latched original x.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared screen geometry, field widths and FSM encoding for the rectangle plot arbiter.
package plot_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int WW = 6;
  localparam int HW = 4;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [WW-1:0] w;
    logic [HW-1:0] h;
    logic [CW-1:0] colour;
  } rect_t;

  // Sums carry one extra bit so a wrapped coordinate still reads as off-screen.
  function automatic logic on_screen(input logic [XW:0] sx, input logic [YW:0] sy);
    return (sx < (XW+1)'(SCREEN_W)) && (sy < (YW+1)'(SCREEN_H));
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above pointer, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_req[(int'(i_rr) + k) % N]) begin
        o_valid  = 1'b1;
        o_idx    = IW'((int'(i_rr) + k) % N);
        o_onehot[(int'(i_rr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rect_plot_arbiter.sv
// Round-robin owner of the VGA pixel port: latches one rectangle and rasterises it
// one pixel per clock, suppressing plot for off-screen pixels.
module rect_plot_arbiter
  import plot_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*YW-1:0] req_y,
  input  logic [NUM_REQ*WW-1:0] req_w,
  input  logic [NUM_REQ*HW-1:0] req_h,
  input  logic [NUM_REQ*CW-1:0] req_colour,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [XW-1:0]         out_x,
  output logic [YW-1:0]         out_y,
  output logic [CW-1:0]         out_colour,
  output logic                  plot,
  output logic                  busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              r_state, w_next;
  logic [IW-1:0]       r_win, r_rr, w_idx;
  logic [NUM_REQ-1:0]  r_grant, w_onehot;
  logic                w_valid;
  rect_t               r_rect, w_sel;
  logic [WW-1:0]       r_qx;
  logic [HW-1:0]       r_qy;
  logic                w_xend, w_last, w_draw;
  logic [XW:0]         w_sx;
  logic [YW:0]         w_sy;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req    (req),
    .i_rr     (r_rr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Winner's fields are still held by the requester during GRANT.
  assign w_sel.x      = req_x[XW*r_win +: XW];
  assign w_sel.y      = req_y[YW*r_win +: YW];
  assign w_sel.w      = req_w[WW*r_win +: WW];
  assign w_sel.h      = req_h[HW*r_win +: HW];
  assign w_sel.colour = req_colour[CW*r_win +: CW];

  assign w_xend = (r_qx == r_rect.w - WW'(1));
  assign w_last = w_xend && (r_qy == r_rect.h - HW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_valid) w_next = S_GRANT;
      S_GRANT: w_next = (w_sel.w == '0 || w_sel.h == '0) ? S_DONE : S_DRAW;
      S_DRAW:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win   <= '0;
      r_rr    <= '0;
      r_grant <= '0;
      r_rect  <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_valid) begin
          r_win   <= w_idx;
          r_grant <= w_onehot;
        end
        S_GRANT: begin
          r_rect <= w_sel;
          r_qx   <= '0;
          r_qy   <= '0;
        end
        S_DRAW: begin
          if (w_xend) begin
            r_qx <= '0;
            r_qy <= r_qy + HW'(1);
          end else begin
            r_qx <= r_qx + WW'(1);
          end
        end
        S_DONE: r_rr <= (r_win == IW'(NUM_REQ-1)) ? '0 : r_win + IW'(1);
        default: ;
      endcase
    end
  end

  assign w_draw = (r_state == S_DRAW);
  assign w_sx   = {1'b0, r_rect.x} + {{(XW+1-WW){1'b0}}, r_qx};
  assign w_sy   = {1'b0, r_rect.y} + {{(YW+1-HW){1'b0}}, r_qy};

  assign out_x      = w_draw ? w_sx[XW-1:0] : '0;
  assign out_y      = w_draw ? w_sy[YW-1:0] : '0;
  assign out_colour = w_draw ? r_rect.colour : '0;
  assign plot       = w_draw && on_screen(w_sx, w_sy);
  assign busy       = (r_state != S_IDLE);
  assign grant      = busy ? r_grant : '0;
  assign done       = (r_state == S_DONE) ? r_grant : '0;
endmodule
